// File: rtl/aegnn_pkg.sv
// Shared definitions for the AEGNN datapath blocks: FIFO read-controller
// state encoding and default counter widths.
`timescale 1ns/1ps

package aegnn;

   // Matches the data-count width of the event FIFOs.
   localparam int FIFO_RD_CNT_W = 12;

   // Output buffer of the FIFO read controller: two entries, so occupancy 0..2.
   localparam int FIFO_RD_SKID_DEPTH = 2;
   localparam int FIFO_RD_OCC_W      = 2;

   typedef enum logic [1:0] {
      FRD_IDLE,
      FRD_RUN,
      FRD_DONE
   } fifo_rd_state_e;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// fifo_rd_skid: 2-entry in-order buffer that absorbs the one-cycle FIFO read
// latency. Entry 0 is always the head. With FIFO_RD_LAST_EN defined each
// entry also carries a last-word flag.
`timescale 1ns/1ps

module fifo_rd_skid
   import aegnn::*;
#(
   parameter int WIDTH = 32
)(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
`ifdef FIFO_RD_LAST_EN
   input  logic                     i_push_last,
   output logic                     o_head_last,
`endif
   input  logic                     i_pop,
   output logic [FIFO_RD_OCC_W-1:0] o_occ,
   output logic [WIDTH-1:0]         o_head_data
);

`ifdef FIFO_RD_LAST_EN
   localparam int EW = WIDTH + 1;
`else
   localparam int EW = WIDTH;
`endif

   logic [EW-1:0]            r_ent0;
   logic [EW-1:0]            r_ent1;
   logic [FIFO_RD_OCC_W-1:0] r_occ;
   logic [EW-1:0]            w_push_ent;

`ifdef FIFO_RD_LAST_EN
   assign w_push_ent  = {i_push_last, i_push_data};
   assign o_head_last = r_ent0[WIDTH];
`else
   assign w_push_ent  = i_push_data;
`endif

   assign o_occ       = r_occ;
   assign o_head_data = r_ent0[WIDTH-1:0];

   // Shift-style buffer: pops move entry 1 forward, pushes land at the tail.
   // NOTE: the two data entries are reset as well, because the head drives
   // m_data directly and that output has a defined reset value of zero.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_occ  <= '0;
         r_ent0 <= '0;
         r_ent1 <= '0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_ent0 <= w_push_ent;
               else               r_ent1 <= w_push_ent;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_ent0 <= r_ent1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_ent0 <= w_push_ent;
               end else begin
                  r_ent0 <= r_ent1;
                  r_ent1 <= w_push_ent;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops exactly `len` words from a read-latency-1 FIFO on a
// start pulse and streams them out on valid/ready with full back-pressure.
// Optional feature macro: FIFO_RD_LAST_EN (adds m_last marking the final word).
`timescale 1ns/1ps

module fifo_burst_reader
   import aegnn::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = FIFO_RD_CNT_W
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_empty,
   input  logic             fifo_rd_rst_busy,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready
`ifdef FIFO_RD_LAST_EN
   ,output logic            m_last
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   fifo_rd_state_e           r_state;
   fifo_rd_state_e           w_state_nxt;
   logic [CNT_W-1:0]         r_len;
   logic [CNT_W-1:0]         r_issued;
   logic [CNT_W-1:0]         r_delivered;
   logic                     r_inflight;
   logic [FIFO_RD_OCC_W-1:0] w_occ;
   logic [WIDTH-1:0]         w_head_data;
   logic                     w_pop;
   logic                     w_credit;
   logic                     w_rd_en;
   logic                     w_burst_end;
   logic                     w_busy;
   logic                     w_done;

   assign m_valid = (w_occ != '0);
   assign m_data  = w_head_data;
   assign w_pop   = m_valid & m_ready;

   // A read may issue only if, after this cycle's pop, the buffer still has
   // room for both the word already in flight and the new one.
   assign w_credit = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

   assign w_rd_en = (r_state == FRD_RUN) & ~fifo_empty & ~fifo_rd_rst_busy &
                    (r_issued != r_len) & w_credit;
   assign fifo_rd_en = w_rd_en;

   // The burst is complete once the last word leaves the buffer. Evaluating
   // this on the post-pop count lets done follow the final pop directly; the
   // buffer is necessarily empty then, since only len words are ever issued.
   assign w_burst_end = (r_delivered == r_len) |
                        (w_pop & (r_delivered == (r_len - CNT_ONE)));

   // State register.
   // NOTE: every clocked block uses non-blocking assignments so that all
   // registers sample pre-edge values regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= FRD_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and status outputs.
   // NOTE: defaults come first so no path leaves a signal unassigned, which
   // would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         FRD_IDLE: begin
            if (start) w_state_nxt = (len == '0) ? FRD_DONE : FRD_RUN;
         end
         FRD_RUN: begin
            w_busy = 1'b1;
            if (w_burst_end) w_state_nxt = FRD_DONE;
         end
         FRD_DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = FRD_IDLE;
         end
         default: w_state_nxt = FRD_IDLE;
      endcase
   end

   assign busy = w_busy;
   assign done = w_done;

   // Burst length latch, issue/delivery counters and read-latency tracking.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_len       <= '0;
         r_issued    <= '0;
         r_delivered <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if ((r_state == FRD_IDLE) && start) begin
            r_len       <= len;
            r_issued    <= '0;
            r_delivered <= '0;
         end else begin
            if (w_rd_en) r_issued <= r_issued + CNT_ONE;
            if (w_pop && (r_delivered != r_len)) r_delivered <= r_delivered + CNT_ONE;
         end
      end
   end

`ifdef FIFO_RD_LAST_EN
   logic r_inflight_last;
   logic w_head_last;

   // Tag the read that makes issued reach len; the tag travels with the data.
   always_ff @(posedge clk) begin
      if (!rstn) r_inflight_last <= 1'b0;
      else       r_inflight_last <= w_rd_en & (r_issued == (r_len - CNT_ONE));
   end

   assign m_last = m_valid & w_head_last;
`endif

   fifo_rd_skid #(
      .WIDTH       (WIDTH)
   ) u_skid (
      .clk         (clk),
      .rstn        (rstn),
      .i_push      (r_inflight),
      .i_push_data (fifo_dout),
`ifdef FIFO_RD_LAST_EN
      .i_push_last (r_inflight_last),
      .o_head_last (w_head_last),
`endif
      .i_pop       (w_pop),
      .o_occ       (w_occ),
      .o_head_data (w_head_data)
   );

endmodule
